// File: rtl/rf_alu_pkg.sv
// Shared definitions for the rf_alu_exec execute unit: ALU op codes,
// PSR flag bit positions and the iterative shifter state encoding.
package rf_alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_MOV = 4'd5;
    localparam logic [3:0] ALU_CMP = 4'd6;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

endpackage

// File: rtl/rf_shift_unit.sv
// Shifter for rf_alu_exec. Default build: iterative 1-bit-per-cycle shifter
// with a down-counter and IDLE/SHIFT FSM. With BARREL_SHIFT_EN defined a
// single-cycle barrel shifter is used instead and o_busy is always 0.
// o_done marks the cycle whose closing edge must register o_res/o_carry.
module rf_shift_unit
    import rf_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SHBITS = $clog2(WIDTH)
) (
`ifndef BARREL_SHIFT_EN
    input  logic              i_clk,
    input  logic              i_reset_n,
`endif
    input  logic              i_start,
    input  logic [WIDTH-1:0]  i_src,
    input  logic [SHBITS-1:0] i_amt,
    input  logic              i_dir,
    input  logic              i_arith,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_res,
    output logic              o_carry,
    output logic              o_carry_upd
);

`ifndef BARREL_SHIFT_EN

    // Returns {bit shifted out, shifted value}; arithmetic only affects right shifts.
    function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic dir, input logic arith);
        if (!dir)
            shift1 = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
        else
            shift1 = {v[0], arith & v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    shift_state_e      r_state;
    shift_state_e      w_state_nxt;
    logic [SHBITS-1:0] r_cnt;
    logic [WIDTH-1:0]  r_val;
    logic              r_dir;
    logic              r_arith;
    logic [WIDTH-1:0]  w_step_val;
    logic              w_step_c;

    assign {w_step_c, w_step_val} = shift1(r_val, r_dir, r_arith);
    assign o_busy = (r_state == ST_SHIFT);

    // FSM state and remaining-bit counter; reset abandons any shift in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE)
                r_cnt <= i_amt;
            else
                r_cnt <= r_cnt - SHBITS'(1);
        end
    end

    // Operand capture while idle, then one bit of shifting per SHIFT cycle.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_IDLE) begin
            r_val   <= i_src;
            r_dir   <= i_dir;
            r_arith <= i_arith;
        end else begin
            r_val <= w_step_val;
        end
    end

    // Next state and completion outputs; k=0 completes immediately as pass-through.
    always_comb begin
        w_state_nxt = r_state;
        o_done      = 1'b0;
        o_res       = i_src;
        o_carry     = 1'b0;
        o_carry_upd = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_amt == '0)
                        o_done = 1'b1;
                    else
                        w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_res       = w_step_val;
                o_carry     = w_step_c;
                o_carry_upd = 1'b1;
                if (r_cnt == SHBITS'(1)) begin
                    o_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

`else

    // One guard bit beyond each end of the operand catches the last bit out.
    logic [WIDTH:0]        w_left;
    logic [WIDTH:0]        w_srl;
    logic signed [WIDTH:0] w_sra;
    logic [WIDTH:0]        w_right;

    assign w_left  = {1'b0, i_src} << i_amt;
    assign w_srl   = {i_src, 1'b0} >> i_amt;
    assign w_sra   = $signed({i_src, 1'b0}) >>> i_amt;
    assign w_right = i_arith ? w_sra : w_srl;

    assign o_busy      = 1'b0;
    assign o_done      = i_start;
    assign o_carry_upd = (i_amt != '0);

    // Direction select between the left and right shifted values.
    always_comb begin
        o_res   = w_left[WIDTH-1:0];
        o_carry = w_left[WIDTH];
        if (i_dir) begin
            o_res   = w_right[WIDTH:1];
            o_carry = w_right[0];
        end
    end

`endif

endmodule

// File: rtl/rf_alu_exec.sv
// rf_alu_exec: register-file read with writeback forwarding, ALU or shifter,
// registered result/PSR and one-stage register writeback.
// BARREL_SHIFT_EN selects the single-cycle shifter; otherwise shifts by k>=1
// take k cycles with in_ready low.
module rf_alu_exec
    import rf_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int SHBITS  = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         aluControl,
    input  logic               shiftOrALU,
    input  logic               shiftDir,
    input  logic               shiftType,
    input  logic               alusrcb,
    input  logic [REGBITS-1:0] regAddress1,
    input  logic [REGBITS-1:0] regAddress2,
    input  logic [REGBITS-1:0] regDest,
    input  logic [WIDTH-1:0]   immediate,
    output logic               result_valid,
    output logic [WIDTH-1:0]   result,
    output logic [7:0]         PSR
);

    logic [WIDTH-1:0]   r_mem [2**REGBITS];
    logic               r_result_valid;
    logic [WIDTH-1:0]   r_result;
    logic [7:0]         r_psr;
    logic               r_wb_we;
    logic [REGBITS-1:0] r_wb_dest;
    logic [WIDTH-1:0]   r_wb_data;
    logic [REGBITS-1:0] r_sh_dest;

    logic               w_accept;
    logic [WIDTH-1:0]   w_rd1, w_rd2, w_src1, w_src2;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_alu_res;
    logic [7:0]         w_alu_psr;
    logic               w_alu_we;
    logic               w_alu_done;
    logic               w_sh_busy, w_sh_done, w_sh_carry, w_sh_carry_upd;
    logic [WIDTH-1:0]   w_sh_res;
    logic [7:0]         w_sh_psr;
    logic [REGBITS-1:0] w_sh_dest;

    assign in_ready     = ~w_sh_busy;
    assign w_accept     = in_valid & in_ready;
    assign w_alu_done   = w_accept & shiftOrALU;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign PSR          = r_psr;

    // A pending writeback wins over the array so dependent ops run back-to-back.
    assign w_rd1  = (r_wb_we && (r_wb_dest == regAddress1)) ? r_wb_data : r_mem[regAddress1];
    assign w_rd2  = (r_wb_we && (r_wb_dest == regAddress2)) ? r_wb_data : r_mem[regAddress2];
    assign w_src1 = w_rd1;
    assign w_src2 = alusrcb ? immediate : w_rd2;

    assign w_sum  = {1'b0, w_src1} + {1'b0, w_src2};
    assign w_diff = {1'b0, w_src1} - {1'b0, w_src2};

    // ALU result, next PSR and writeback enable; CMP shows the difference without writing it.
    always_comb begin
        w_alu_res = '0;
        w_alu_psr = r_psr;
        w_alu_we  = 1'b0;
        case (aluControl)
            ALU_ADD: begin
                w_alu_res        = w_sum[WIDTH-1:0];
                w_alu_we         = 1'b1;
                w_alu_psr[PSR_C] = w_sum[WIDTH];
                w_alu_psr[PSR_F] = (w_src1[WIDTH-1] == w_src2[WIDTH-1]) &&
                                   (w_alu_res[WIDTH-1] != w_src1[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu_res        = w_diff[WIDTH-1:0];
                w_alu_we         = 1'b1;
                w_alu_psr[PSR_C] = w_diff[WIDTH];
                w_alu_psr[PSR_F] = (w_src1[WIDTH-1] != w_src2[WIDTH-1]) &&
                                   (w_alu_res[WIDTH-1] != w_src1[WIDTH-1]);
            end
            ALU_AND: begin w_alu_res = w_src1 & w_src2; w_alu_we = 1'b1; end
            ALU_OR:  begin w_alu_res = w_src1 | w_src2; w_alu_we = 1'b1; end
            ALU_XOR: begin w_alu_res = w_src1 ^ w_src2; w_alu_we = 1'b1; end
            ALU_MOV: begin w_alu_res = w_src2;          w_alu_we = 1'b1; end
            ALU_CMP: begin
                w_alu_res        = w_diff[WIDTH-1:0];
                w_alu_psr[PSR_Z] = (w_src1 == w_src2);
                w_alu_psr[PSR_L] = w_diff[WIDTH];
                w_alu_psr[PSR_N] = $signed(w_src1) < $signed(w_src2);
            end
            default: ;
        endcase
        if (aluControl <= ALU_MOV) begin
            w_alu_psr[PSR_Z] = (w_alu_res == '0);
            w_alu_psr[PSR_N] = w_alu_res[WIDTH-1];
        end
    end

    rf_shift_unit #(
        .WIDTH  (WIDTH),
        .SHBITS (SHBITS)
    ) u_shift (
`ifndef BARREL_SHIFT_EN
        .i_clk       (clk),
        .i_reset_n   (reset),
`endif
        .i_start     (w_accept & ~shiftOrALU),
        .i_src       (w_src1),
        .i_amt       (w_src2[SHBITS-1:0]),
        .i_dir       (shiftDir),
        .i_arith     (shiftType),
        .o_busy      (w_sh_busy),
        .o_done      (w_sh_done),
        .o_res       (w_sh_res),
        .o_carry     (w_sh_carry),
        .o_carry_upd (w_sh_carry_upd)
    );

    // Shift flags: C only when a bit actually left the word, Z/N from the result.
    always_comb begin
        w_sh_psr        = r_psr;
        w_sh_psr[PSR_C] = w_sh_carry_upd ? w_sh_carry : r_psr[PSR_C];
        w_sh_psr[PSR_Z] = (w_sh_res == '0);
        w_sh_psr[PSR_N] = w_sh_res[WIDTH-1];
    end

    assign w_sh_dest = w_sh_busy ? r_sh_dest : regDest;

    // Destination of a multi-cycle shift, held until it completes.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_sh_dest <= regDest;
    end

    // Result, flags, valid pulse and writeback enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_psr          <= '0;
            r_wb_we        <= 1'b0;
        end else begin
            r_result_valid <= w_alu_done | w_sh_done;
            r_wb_we        <= 1'b0;
            if (w_alu_done) begin
                r_result <= w_alu_res;
                r_psr    <= w_alu_psr;
                r_wb_we  <= w_alu_we;
            end else if (w_sh_done) begin
                r_result <= w_sh_res;
                r_psr    <= w_sh_psr;
                r_wb_we  <= 1'b1;
            end
        end
    end

    // Writeback stage address/data.
    always_ff @(posedge clk) begin
        if (w_alu_done) begin
            r_wb_dest <= regDest;
            r_wb_data <= w_alu_res;
        end else if (w_sh_done) begin
            r_wb_dest <= w_sh_dest;
            r_wb_data <= w_sh_res;
        end
    end

    // Register array write, one edge after the result is registered.
    always_ff @(posedge clk) begin
        if (r_wb_we)
            r_mem[r_wb_dest] <= r_wb_data;
    end

endmodule

// File: tb/tb_rf_alu_exec.sv
// Directed bench for rf_alu_exec with a result/PSR scoreboard.
module tb_rf_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluControl;
    logic        shiftOrALU, shiftDir, shiftType, alusrcb;
    logic [3:0]  regAddress1, regAddress2, regDest;
    logic [15:0] immediate;
    logic        result_valid;
    logic [15:0] result;
    logic [7:0]  PSR;

    always #5 clk = ~clk;

`ifdef BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    rf_alu_exec #(.WIDTH(16), .REGBITS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluControl(aluControl), .shiftOrALU(shiftOrALU), .shiftDir(shiftDir),
        .shiftType(shiftType), .alusrcb(alusrcb), .regAddress1(regAddress1),
        .regAddress2(regAddress2), .regDest(regDest), .immediate(immediate),
        .result_valid(result_valid), .result(result), .PSR(PSR)
    );

    typedef struct packed {
        logic        chk;
        logic [15:0] r;
        logic [7:0]  p;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic alu, input logic [3:0] ctl, input logic dir,
                         input logic typ, input logic srcb, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] d, input logic [15:0] imm,
                         input bit expect_out, input bit chk_res, input logic [15:0] er,
                         input logic [7:0] ep, input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait: in_ready actual 0 required 1 within %0d cycles", name, n);
        end
        aluControl  = ctl;
        shiftOrALU  = alu;
        shiftDir    = dir;
        shiftType   = typ;
        alusrcb     = srcb;
        regAddress1 = a1;
        regAddress2 = a2;
        regDest     = d;
        immediate   = imm;
        in_valid    = 1'b1;
        if (expect_out) begin
            e.chk = chk_res;
            e.r   = er;
            e.p   = ep;
            sb_q.push_back(e);
            nm_q.push_back(name);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic alu(input logic [3:0] ctl, input logic srcb, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] d, input logic [15:0] imm,
                       input logic [15:0] er, input logic [7:0] ep, input string name);
        issue(1'b1, ctl, 1'b0, 1'b0, srcb, a1, a2, d, imm, 1'b1, ctl != 4'd6, er, ep, name);
        chk({name, "_lat"}, 32'(result_valid), 32'd1);
    endtask

    task automatic shf(input logic dir, input logic typ, input logic [3:0] a1,
                       input logic [3:0] d, input logic [3:0] k,
                       input logic [15:0] er, input logic [7:0] ep, input string name);
        int c, lo;
        issue(1'b0, 4'd0, dir, typ, 1'b1, a1, 4'd0, d, {12'd0, k}, 1'b1, 1'b1, er, ep, name);
        c  = 0;
        lo = 0;
        while (!result_valid && c < 40) begin
            if (!in_ready) lo++;
            @(posedge clk); #1;
            c++;
        end
        chk({name, "_lat"}, 32'(c), 32'(BARREL ? 0 : k));
        chk({name, "_rdylow"}, 32'(lo), 32'(BARREL ? 0 : k));
        chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int w;
        reset = 1'b0; in_valid = 1'b0; aluControl = '0; shiftOrALU = 1'b0;
        shiftDir = 1'b0; shiftType = 1'b0; alusrcb = 1'b0;
        regAddress1 = '0; regAddress2 = '0; regDest = '0; immediate = '0;

        fork
            begin : monitor
                exp_t  e;
                string s;
                forever begin
                    @(negedge clk);
                    if (result_valid === 1'b1) begin
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_valid: result %h PSR %h with nothing expected", result, PSR);
                        end else begin
                            e = sb_q.pop_front();
                            s = nm_q.pop_front();
                            if (e.chk) chk({s, "_result"}, 32'(result), 32'(e.r));
                            chk({s, "_psr"}, 32'(PSR), 32'(e.p));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_psr", 32'(PSR), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // register load and forwarded read-back
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd1, 16'h1234, 16'h1234, 8'h00, "mov_r1");
        alu(4'd5, 1'b0, 4'd0, 4'd1, 4'd5, 16'h0000, 16'h1234, 8'h00, "rd_r1");
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd1, 16'h7FFF, 16'h7FFF, 8'h00, "mov_7fff");
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd2, 16'h0001, 16'h0001, 8'h00, "mov_r2");
        // ADD flags
        alu(4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 16'h0000, 16'h8000, 8'hA0, "add_ovf");
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd1, 16'hFFFF, 16'hFFFF, 8'hA0, "mov_ffff");
        alu(4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 16'h0000, 16'h0000, 8'h41, "add_carry");
        // back-to-back dependent ops
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd1, 16'h0001, 16'h0001, 8'h01, "mov_one");
        alu(4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 16'h0000, 16'h0002, 8'h00, "add_r3");
        alu(4'd0, 1'b0, 4'd3, 4'd3, 4'd4, 16'h0000, 16'h0004, 8'h00, "add_fwd");
        alu(4'd5, 1'b0, 4'd0, 4'd4, 4'd6, 16'h0000, 16'h0004, 8'h00, "rd_r4");
        // SUB and logic ops
        alu(4'd1, 1'b1, 4'd1, 4'd0, 4'd9, 16'h0002, 16'hFFFF, 8'h81, "sub_borrow");
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd8, 16'h8000, 16'h8000, 8'h81, "mov_8000");
        alu(4'd1, 1'b1, 4'd8, 4'd0, 4'd9, 16'h0001, 16'h7FFF, 8'h20, "sub_ovf");
        alu(4'd2, 1'b1, 4'd1, 4'd0, 4'd10, 16'h0003, 16'h0001, 8'h20, "and");
        alu(4'd3, 1'b1, 4'd1, 4'd0, 4'd10, 16'h8000, 16'h8001, 8'hA0, "or");
        alu(4'd4, 1'b1, 4'd1, 4'd0, 4'd10, 16'h0001, 16'h0000, 8'h60, "xor");
        // CMP and undefined codes leave r6 alone
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd6, 16'h0BAD, 16'h0BAD, 8'h20, "mov_r6");
        alu(4'd6, 1'b1, 4'd1, 4'd0, 4'd6, 16'hFFFF, 16'h0000, 8'h24, "cmp");
        alu(4'd5, 1'b0, 4'd0, 4'd6, 4'd7, 16'h0000, 16'h0BAD, 8'h24, "rd_r6_cmp");
        alu(4'd7, 1'b1, 4'd1, 4'd0, 4'd6, 16'h1111, 16'h0000, 8'h24, "code7");
        alu(4'd15, 1'b1, 4'd1, 4'd0, 4'd6, 16'h1111, 16'h0000, 8'h24, "code15");
        alu(4'd5, 1'b0, 4'd0, 4'd6, 4'd7, 16'h0000, 16'h0BAD, 8'h24, "rd_r6_inv");
        // shifts
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd11, 16'h8001, 16'h8001, 8'hA4, "mov_8001");
        shf(1'b1, 1'b1, 4'd11, 4'd12, 4'd3, 16'hF000, 8'hA4, "sra3");
        alu(4'd5, 1'b0, 4'd0, 4'd12, 4'd14, 16'h0000, 16'hF000, 8'hA4, "rd_sra");
        shf(1'b0, 1'b0, 4'd11, 4'd13, 4'd1, 16'h0002, 8'h25, "sll1");
        shf(1'b0, 1'b0, 4'd11, 4'd13, 4'd0, 16'h8001, 8'hA5, "sh0");
        shf(1'b1, 1'b0, 4'd11, 4'd13, 4'd1, 16'h4000, 8'h25, "srl1");
        shf(1'b0, 1'b1, 4'd11, 4'd13, 4'd4, 16'h0010, 8'h24, "sla4");
        // reset during a long shift
        alu(4'd5, 1'b1, 4'd0, 4'd0, 4'd7, 16'h5555, 16'h5555, 8'h24, "mov_5555");
        issue(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 4'd7, 16'd10, BARREL, 1'b1,
              16'h0015, 8'h24, "srl10");
        @(posedge clk); #1;
        chk("abort_busy", 32'(in_ready), 32'(BARREL ? 1 : 0));
        reset = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_psr", 32'(PSR), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        alu(4'd5, 1'b0, 4'd0, 4'd7, 4'd8, 16'h0000, BARREL ? 16'h0015 : 16'h5555, 8'h00, "rd_r7");
        shf(1'b1, 1'b1, 4'd7, 4'd9, 4'd2, BARREL ? 16'h0005 : 16'h1555, 8'h00, "sra2_post");

        w = 0;
        while (sb_q.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
